// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode constants and the decoded bundle type.
// The bundle is sized for the widest datapath; narrower stages zero the upper bits.
package riscv_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE_0  = 7'b0010011;
  localparam logic [6:0] I_TYPE_1  = 7'b0000011;
  localparam logic [6:0] I_TYPE_2  = 7'b1100111;
  localparam logic [6:0] I_TYPE_3  = 7'b0001111;
  localparam logic [6:0] I_TYPE_4  = 7'b1110011;
  localparam logic [6:0] S_TYPE    = 7'b0100011;
  localparam logic [6:0] B_TYPE    = 7'b1100011;
  localparam logic [6:0] U_TYPE_0  = 7'b0110111;
  localparam logic [6:0] U_TYPE_1  = 7'b0010111;
  localparam logic [6:0] J_TYPE    = 7'b1101111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                r;
    logic                i;
    logic                s;
    logic                b;
    logic                u;
    logic                j;
    logic                illegal;
    logic [XLEN_MAX-1:0] imm;
  } dec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RISC-V instruction decoder producing one dec_t bundle.
// Immediates are built 64 bits wide, then masked to XLEN so narrow builds read zero above.
module rv_decode_comb
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output dec_t            dec_o
);

  logic signed [XLEN_MAX-1:0] w_imm_full;
  logic        [XLEN_MAX-1:0] w_xlen_mask;
  logic                       w_quad_ok;

  assign w_xlen_mask = (XLEN == 64) ? {XLEN_MAX{1'b1}} : 64'h0000_0000_FFFF_FFFF;
  assign w_quad_ok   = (instr_i[1:0] == 2'b11);

  always_comb begin
    dec_o        = '0;
    w_imm_full   = '0;
    dec_o.pc     = XLEN_MAX'(pc_i);
    dec_o.rs1    = instr_i[19:15];
    dec_o.rs2    = instr_i[24:20];
    dec_o.rd     = instr_i[11:7];
    dec_o.op     = instr_i[6:0];
    dec_o.funct3 = instr_i[14:12];
    dec_o.funct7 = instr_i[31:25];

    if (w_quad_ok) begin
      case (instr_i[6:0])
        R_TYPE:    dec_o.r = 1'b1;
        OP_32:     dec_o.r = (RV64_OPS != 0);
        I_TYPE_0, I_TYPE_1, I_TYPE_2, I_TYPE_3, I_TYPE_4:
                   dec_o.i = 1'b1;
        OP_IMM_32: dec_o.i = (RV64_OPS != 0);
        S_TYPE:    dec_o.s = 1'b1;
        B_TYPE:    dec_o.b = 1'b1;
        U_TYPE_0, U_TYPE_1:
                   dec_o.u = 1'b1;
        J_TYPE:    dec_o.j = 1'b1;
        default:   ;
      endcase
    end

    dec_o.illegal = ~(dec_o.r | dec_o.i | dec_o.s | dec_o.b | dec_o.u | dec_o.j);

    // U-type upper immediate sign-extends from bit 31; masking leaves it unextended at XLEN=32
    if (dec_o.i)
      w_imm_full = {{52{instr_i[31]}}, instr_i[31:20]};
    else if (dec_o.s)
      w_imm_full = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    else if (dec_o.b)
      w_imm_full = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    else if (dec_o.u)
      w_imm_full = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
    else if (dec_o.j)
      w_imm_full = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    dec_o.imm = w_imm_full & w_xlen_mask;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register plus one skid entry around rv_decode_comb,
// giving 1-cycle latency, full throughput and a registered in_ready.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output dec_t            dec_o
);

  dec_t w_dec_p0;
  dec_t r_out_p1;
  dec_t r_skid_p1;
  logic r_vld_p1;
  logic r_skid_vld_p1;
  logic w_accept;
  logic w_out_free;

  rv_decode_comb #(
    .XLEN     (XLEN),
    .RV64_OPS (RV64_OPS)
  ) u_decode (
    .instr_i (instr_i),
    .pc_i    (pc_i),
    .dec_o   (w_dec_p0)
  );

  assign in_ready_o  = ~r_skid_vld_p1;
  assign w_accept    = in_valid_i & ~r_skid_vld_p1;
  assign w_out_free  = ~r_vld_p1 | out_ready_i;
  assign out_valid_o = r_vld_p1;
  assign dec_o       = r_out_p1;

  // p0 -> p1: decode result enters out register directly, or parks in skid while out stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_out_p1      <= '0;
      r_skid_p1     <= '0;
    end else if (flush_i) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_vld_p1) begin
        r_out_p1      <= r_skid_p1;
        r_vld_p1      <= 1'b1;
        r_skid_vld_p1 <= 1'b0;
      end else if (w_accept) begin
        r_out_p1 <= w_dec_p0;
        r_vld_p1 <= 1'b1;
      end else begin
        r_vld_p1 <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_p1     <= w_dec_p0;
      r_skid_vld_p1 <= 1'b1;
    end
  end

endmodule
